keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad on the 100 MHz system clock. It drives one column low at a time, reads the rows, debounces, and reports each key press as a 4-bit code with a one-cycle valid strobe. This is the input-side counterpart of the multiplexed display scanner: that block drives digits out, this block reads keys in. It feeds the user-interface control logic alongside the display path.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/scan_tick_gen.sv | 29 ++
 rtl/keypad_scanner.sv | 203 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StHeld     = 2'd2
  } kp_state_e;

  localparam logic [3:0]  COL_RESET     = 4'b1110;
  localparam int unsigned CODE_W        = 4;
  localparam int unsigned REPEAT_FIRST  = 500;
  localparam int unsigned REPEAT_PERIOD = 100;

  // Index of the lowest zero bit; used for row priority and column index.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell-rate tick generator shared by scanned peripherals.
// Pulses tick for one cycle every CLK_HZ/SCAN_HZ cycles.
module scan_tick_gen #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic CLK_100MHZ,
  input  logic RST,
  output logic tick
);

  localparam int unsigned DWELL = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(DWELL - 1));

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce; one KEY_VALID pulse per accepted key.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              CLK_100MHZ,
  input  logic              RST,
  output logic [3:0]        COL,
  input  logic [3:0]        ROW,
  output logic [CODE_W-1:0] KEY_CODE,
  output logic              KEY_VALID,
  output logic              KEY_HELD
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  logic tick;

  scan_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) u_tick (
    .CLK_100MHZ(CLK_100MHZ),
    .RST       (RST),
    .tick      (tick)
  );

  // Two-flop synchronizer; idle rows read as released.
  logic [3:0] row_meta_q, rs_q;

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
    end else begin
      row_meta_q <= ROW;
      rs_q       <= row_meta_q;
    end
  end

  kp_state_e         state_q, state_d;
  logic [3:0]        col_q, col_d;
  logic [1:0]        cand_row_q, cand_row_d;
  logic [1:0]        cand_col_q, cand_col_d;
  logic [3:0]        deb_cnt_q, deb_cnt_d;
  logic [3:0]        rel_cnt_q, rel_cnt_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic              accept;
  logic [CODE_W-1:0] acc_code;
  logic [3:0]        col_rot;
  logic [3:0]        deb_inc, rel_inc;

`ifdef KEYPAD_REPEAT_EN
  logic [9:0] rep_cnt_q, rep_cnt_d;
  logic [9:0] rep_inc;
`endif

  assign col_rot = {col_q[2:0], col_q[3]};
  assign deb_inc = deb_cnt_q + 4'd1;
  assign rel_inc = rel_cnt_q + 4'd1;
`ifdef KEYPAD_REPEAT_EN
  assign rep_inc = rep_cnt_q + 10'd1;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    acc_code    = key_code_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif

    unique case (state_q)
      StScan: begin
        if (tick) begin
          if (rs_q == 4'hF) begin
            col_d = col_rot;
          end else begin
            cand_row_d = low_idx(rs_q);
            cand_col_d = low_idx(col_q);
            deb_cnt_d  = 4'd1;
            if (DEB_N == 4'd1) begin
              accept   = 1'b1;
              acc_code = {low_idx(rs_q), low_idx(col_q)};
            end else begin
              state_d = StDebounce;
            end
          end
        end
      end

      StDebounce: begin
        if (tick) begin
          if (!rs_q[cand_row_q]) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_N) begin
              accept   = 1'b1;
              acc_code = {cand_row_q, cand_col_q};
            end
          end else begin
            state_d = StScan;
            col_d   = col_rot;
          end
        end
      end

      StHeld: begin
        if (tick) begin
`ifdef KEYPAD_REPEAT_EN
          // First repeat after REPEAT_FIRST ticks, then fold back to re-arm every period.
          if (rep_inc == 10'(REPEAT_FIRST + REPEAT_PERIOD)) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = 10'(REPEAT_FIRST);
          end else begin
            key_valid_d = (rep_inc == 10'(REPEAT_FIRST));
            rep_cnt_d   = rep_inc;
          end
`endif
          if (rs_q[cand_row_q]) begin
            rel_cnt_d = rel_inc;
            if (rel_inc == DEB_N) begin
              key_held_d  = 1'b0;
              key_valid_d = 1'b0;
              rel_cnt_d   = 4'd0;
              state_d     = StScan;
              col_d       = col_rot;
            end
          end else begin
            rel_cnt_d = 4'd0;
          end
        end
      end

      default: state_d = StScan;
    endcase

    if (accept) begin
      state_d     = StHeld;
      key_code_d  = acc_code;
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      rel_cnt_d   = 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d   = 10'd0;
`endif
    end
  end

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      state_q     <= StScan;
      col_q       <= COL_RESET;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      deb_cnt_q   <= 4'd0;
      rel_cnt_q   <= 4'd0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      rep_cnt_q <= 10'd0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign COL       = col_q;
  assign KEY_CODE  = key_code_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_HELD  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix model driving ROW from COL.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col, row, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys;  // bit r*4+c set means key (row r, col c) is pressed

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int v_count  = 0;
  int last_v_cyc = 0;
  logic [3:0] v_code = 4'h0;
  logic prev_valid = 1'b0;
  int wide_pulses = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .CLK_HZ        (100),
    .SCAN_HZ       (10),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .CLK_100MHZ(clk),
    .RST       (rst),
    .COL       (col),
    .ROW       (row),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .KEY_HELD  (key_held)
  );

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid) begin
      v_count++;
      last_v_cyc = cyc;
      v_code = key_code;
      if (prev_valid) wide_pulses++;
    end
    prev_valid = key_valid;
  endtask

  // Returns on the first cycle COL newly shows value c.
  task automatic wait_col_edge(input logic [3:0] c, input string tag);
    int i;
    i = 0;
    while (col === c && i < 100) begin step(); i++; end
    while (col !== c && i < 100) begin step(); i++; end
    check_eq(tag, col, c);
  endtask

  task automatic wait_valid(input int budget, input string tag, output int lat);
    int i;
    i = 0;
    while (!key_valid && i < budget) begin step(); i++; end
    check_eq(tag, key_valid, 1'b1);
    lat = i;
  endtask

  task automatic wait_release(input int budget, input string tag, output int d);
    int i;
    i = 0;
    while (key_held && i < budget) begin step(); i++; end
    check_eq(tag, key_held, 1'b0);
    d = i;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_seq [4];
    int v0, t0, lat, d, chg_cyc;
    exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1011; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1110;

    // Reset, no keys
    keys = 16'h0;
    rst  = 1'b1;
    repeat (3) step();
    check_eq("rst_col", col, 4'b1110);
    check_eq("rst_code", key_code, 4'h0);
    check_eq("rst_valid", key_valid, 1'b0);
    check_eq("rst_held", key_held, 1'b0);
    rst = 1'b0;
    cyc = 0;
    v0  = v_count;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] prev;
      int i;
      prev = col;
      i = 0;
      while (col === prev && i < 20) begin step(); i++; end
      chg_cyc = cyc;
      check_eq("idle_col_seq", col, exp_seq[k]);
      check_eq("idle_col_time", chg_cyc, 10 * (k + 1));
    end
    check_eq("idle_no_valid", v_count - v0, 0);

    // Key row 2 col 1 held for 200 cycles
    wait_col_edge(4'b1101, "k9_wait_col");
    v0 = v_count;
    t0 = cyc;
    keys[2*4+1] = 1'b1;
    wait_valid(80, "k9_valid", lat);
    check_eq("k9_latency_ok", (lat <= 63), 1'b1);
    check_eq("k9_code", v_code, 4'h9);
    step();
    check_eq("k9_held", key_held, 1'b1);
    check_eq("k9_pulse_1cyc", key_valid, 1'b0);
    while (cyc - t0 < 200) step();
    check_eq("k9_still_held", key_held, 1'b1);
    keys = 16'h0;
    wait_release(50, "k9_release", d);
    check_eq("k9_release_delay", (d >= 20 && d <= 35), 1'b1);
    check_eq("k9_col_after", col, 4'b1011);
    check_eq("k9_one_pulse", v_count - v0, 1);

    // Short glitch on row 0 col 0
    wait_col_edge(4'b1110, "glitch_wait_col");
    v0 = v_count;
    keys[0] = 1'b1;
    repeat (15) step();
    keys = 16'h0;
    repeat (10) step();
    check_eq("glitch_col", col, 4'b1101);
    check_eq("glitch_no_valid", v_count - v0, 0);
    check_eq("glitch_code_kept", key_code, 4'h9);
    check_eq("glitch_not_held", key_held, 1'b0);

    // Rows 1 and 3 together in col 3
    wait_col_edge(4'b0111, "multi_wait_col");
    keys[1*4+3] = 1'b1;
    keys[3*4+3] = 1'b1;
    wait_valid(80, "multi_valid", lat);
    check_eq("multi_code", v_code, 4'h7);
    repeat (20) step();
    keys = 16'h0;
    wait_release(50, "multi_release", d);

    // Reset during debounce
    wait_col_edge(4'b1101, "rst_wait_col");
    keys[2*4+1] = 1'b1;
    repeat (12) step();
    check_eq("deb_not_held", key_held, 1'b0);
    check_eq("deb_code_pre", key_code, 4'h7);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_col", col, 4'b1110);
    check_eq("mid_rst_code", key_code, 4'h0);
    check_eq("mid_rst_held", key_held, 1'b0);
    check_eq("mid_rst_valid", key_valid, 1'b0);
    keys = 16'h0;
    repeat (3) step();
    rst = 1'b0;
    v0 = v_count;
    repeat (60) step();
    check_eq("post_rst_no_valid", v_count - v0, 0);
    check_eq("post_rst_code", key_code, 4'h0);

`ifdef KEYPAD_REPEAT_EN
    begin
      int c1;
      int pulses [$];
      wait_col_edge(4'b1110, "rep_wait_col");
      keys[0] = 1'b1;
      wait_valid(80, "rep_first", lat);
      c1 = cyc;
      for (int i = 0; i < 6900; i++) begin
        step();
        if (key_valid) pulses.push_back(cyc);
      end
      check_eq("rep_count", pulses.size(), 2);
      if (pulses.size() == 2) begin
        check_eq("rep_t500", pulses[0] - c1, 5000);
        check_eq("rep_t600", pulses[1] - c1, 6000);
      end
      keys = 16'h0;
      wait_release(50, "rep_release", d);
    end
`endif

    check_eq("no_wide_pulses", wide_pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
